// File: rtl/loader_pkg.sv
// Shared definitions for multi_bank_loader: FSM states, opcodes and
// instruction byte field positions.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        COMM = 2'd2
    } state_e;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_CMD  = 2'b01;

    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 6;
    localparam int BANK_MSB = 5;
    localparam int BANK_LSB = 0;
    localparam int CODE_MSB = 3;
    localparam int CODE_LSB = 0;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream little-endian into WORD_BYTES-wide words.
// word_o shows the word including the byte presented this cycle, so the
// parent can register it on the same edge that word_done is seen.
module word_packer
    import loader_pkg::*;
#(
    parameter int WORD_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic                    word_done
);
    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [CNT_W-1:0]        lane_q, lane_d;
    logic [8*WORD_BYTES-1:0] lanes_q, lanes_d;

    // Lane steering; a new word starts from all-zero lanes so stale bytes never leak
    always_comb begin
        lane_d    = lane_q;
        lanes_d   = lanes_q;
        word_done = 1'b0;
        if (clear) begin
            lane_d  = '0;
            lanes_d = '0;
        end else if (byte_valid) begin
            if (lane_q == '0) begin
                lanes_d = '0;
            end
            lanes_d[lane_q*8 +: 8] = byte_in;
            if (lane_q == CNT_W'(WORD_BYTES - 1)) begin
                word_done = 1'b1;
                lane_d    = '0;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end
        word_o = lanes_d;
    end

    // Lane counter and lane register
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q  <= '0;
            lanes_q <= '0;
        end else begin
            lane_q  <= lane_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/multi_bank_loader.sv
// Serial front end: decodes instruction bytes, loads payload words into one
// of NBANKS BRAM banks and forwards 4-bit commands downstream.
// Optional macro LOADER_CHECKSUM_EN: each load ends with an XOR checksum byte.
module multi_bank_loader
    import loader_pkg::*;
#(
    parameter int NBANKS         = 2,
    parameter int DEPTH          = 1024,
    parameter int WORD_BYTES     = 1,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    input  logic                    done,
    output logic [NBANKS-1:0]       bram_we,
    output logic [8*WORD_BYTES-1:0] bram_wdata,
    output logic [ADDR_W-1:0]       bram_addr,
    output logic                    cmd_valid,
    output logic [3:0]              cmd,
    output logic [NBANKS-1:0]       bank_ready,
    output logic                    busy,
    output logic                    err,
    output logic [1:0]              state_o
);
    localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DW     = 8 * WORD_BYTES;

    state_e            state_q, state_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [NBANKS-1:0] we_q, we_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic              cmdv_q, cmdv_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [NBANKS-1:0] ready_q, ready_d;
    logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic              chk_q, chk_d;
    logic [7:0]        xor_q, xor_d;
`endif

    logic [NBANKS-1:0] bank_oh, sel_oh;
    logic              sel_ok, load_start, to_hit, in_chk;
    logic              pk_valid, pk_clear, pk_done;
    logic [DW-1:0]     pk_word;

`ifdef LOADER_CHECKSUM_EN
    assign in_chk = chk_q;
`else
    assign in_chk = 1'b0;
`endif

    // One-hot decodes of the active bank and of the bank named by the incoming byte
    always_comb begin
        bank_oh = '0;
        sel_oh  = '0;
        for (int unsigned i = 0; i < NBANKS; i++) begin
            bank_oh[i] = (bank_q == BANK_W'(i));
            sel_oh[i]  = (rx_byte[BANK_MSB:BANK_LSB] == 6'(i));
        end
    end

    // Packer control kept apart from the FSM so word_done does not feed back into its own inputs
    always_comb begin
        sel_ok     = ({1'b0, rx_byte[BANK_MSB:BANK_LSB]} < 7'(NBANKS));
        load_start = (state_q == IDLE) && rx_valid &&
                     (rx_byte[OP_MSB:OP_LSB] == OP_LOAD) && sel_ok;
        to_hit     = (state_q == LOAD) && !rx_valid && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
        pk_valid   = (state_q == LOAD) && rx_valid && !in_chk;
        pk_clear   = load_start || to_hit;
    end

    word_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_in    (rx_byte),
        .word_o     (pk_word),
        .word_done  (pk_done)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        to_d    = to_q;
        we_d    = '0;
        wdata_d = wdata_q;
        baddr_d = baddr_q;
        cmdv_d  = 1'b0;
        cmd_d   = cmd_q;
        ready_d = ready_q;
        err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d   = chk_q;
        xor_d   = xor_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (load_start) begin
                        state_d = LOAD;
                        bank_d  = BANK_W'(rx_byte[BANK_MSB:BANK_LSB]);
                        addr_d  = '0;
                        to_d    = '0;
                        ready_d = ready_q & ~sel_oh;
`ifdef LOADER_CHECKSUM_EN
                        chk_d   = 1'b0;
                        xor_d   = '0;
`endif
                    end else if (rx_byte[OP_MSB:OP_LSB] == OP_CMD) begin
                        cmd_d   = rx_byte[CODE_MSB:CODE_LSB];
                        cmdv_d  = 1'b1;
                        state_d = COMM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    to_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    if (chk_q) begin
                        state_d = IDLE;
                        chk_d   = 1'b0;
                        if (rx_byte == xor_q) begin
                            ready_d = ready_q | bank_oh;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        xor_d = xor_q ^ rx_byte;
`else
                    begin
`endif
                        if (pk_done) begin
                            we_d    = bank_oh;
                            wdata_d = pk_word;
                            baddr_d = addr_q;
                            addr_d  = addr_q + 1'b1;
                            if (addr_q == ADDR_W'(DEPTH - 1)) begin
`ifdef LOADER_CHECKSUM_EN
                                chk_d   = 1'b1;
`else
                                state_d = IDLE;
                                ready_d = ready_q | bank_oh;
`endif
                            end
                        end
                    end
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    to_d    = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = 1'b0;
`endif
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            COMM: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bank_q  <= '0;
            addr_q  <= '0;
            to_q    <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            baddr_q <= '0;
            cmdv_q  <= 1'b0;
            cmd_q   <= '0;
            ready_q <= '0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= 1'b0;
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            to_q    <= to_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            baddr_q <= baddr_d;
            cmdv_q  <= cmdv_d;
            cmd_q   <= cmd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
            xor_q   <= xor_d;
`endif
        end
    end

    assign bram_we    = we_q;
    assign bram_wdata = wdata_q;
    assign bram_addr  = baddr_q;
    assign cmd_valid  = cmdv_q;
    assign cmd        = cmd_q;
    assign bank_ready = ready_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE);
    assign state_o    = state_q;

endmodule

// File: tb/tb_multi_bank_loader.sv
// Directed plus randomized bench for multi_bank_loader (NBANKS=2, DEPTH=4,
// WORD_BYTES=2, short timeout). Honours LOADER_CHECKSUM_EN when defined.
module tb_multi_bank_loader;
    localparam int NB = 2;
    localparam int DP = 4;
    localparam int WB = 2;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        done = 1'b0;
    logic [NB-1:0] bram_we;
    logic [15:0] bram_wdata;
    logic [1:0]  bram_addr;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic [NB-1:0] bank_ready;
    logic        busy;
    logic        err;
    logic [1:0]  state_o;

    always #5 clk = ~clk;

    multi_bank_loader #(
        .NBANKS(NB), .DEPTH(DP), .WORD_BYTES(WB), .ADDR_W(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte), .done(done),
        .bram_we(bram_we), .bram_wdata(bram_wdata), .bram_addr(bram_addr),
        .cmd_valid(cmd_valid), .cmd(cmd), .bank_ready(bank_ready), .busy(busy),
        .err(err), .state_o(state_o)
    );

    int total = 0;
    int bad = 0;

    // Write/event log captured just after each rising edge
    logic [NB-1:0] log_we[256];
    logic [1:0]    log_addr[256];
    logic [15:0]   log_data[256];
    int wn = 0;
    int errn = 0;
    int cvn = 0;
    always @(posedge clk) begin
        #1;
        if (bram_we != '0 && wn < 256) begin
            log_we[wn]   = bram_we;
            log_addr[wn] = bram_addr;
            log_data[wn] = bram_wdata;
            wn++;
        end
        if (err) errn++;
        if (cmd_valid) cvn++;
    end

    logic [7:0]    pl[DP*WB];
    logic [NB-1:0] exp_ready = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called positioned at a falling edge; returns at the next falling edge
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full load of bank b with pl[]; optional long silence after byte gap_at
    task automatic run_load(input int b, input int gap_at, input int gap_len, input bit good);
        int rp = wn;
        int e0 = errn;
        logic [7:0] x = 8'h00;
        logic [15:0] d;
        bit ok = 1'b1;
        send(8'(b));
        exp_ready[b] = 1'b0;
        chk("ready_cleared_on_start", 32'(bank_ready), 32'(exp_ready));
        chk("state_load", 32'(state_o), 32'd1);
        for (int i = 0; i < DP*WB; i++) begin
            send(pl[i]);
            x = x ^ pl[i];
            if (i == gap_at) idle(gap_len);
            else if (i != DP*WB-1) idle(int'($urandom_range(0, 1)));
        end
`ifdef LOADER_CHECKSUM_EN
        if (good) send(x);
        else send((x == 8'h00) ? 8'h01 : 8'h00);
        ok = good;
`endif
        idle(1);
        exp_ready[b] = ok;
        chk("write_count", 32'(wn - rp), DP);
        for (int k = 0; k < DP; k++) begin
            d = '0;
            for (int j = 0; j < WB; j++) d = d | (16'(pl[k*WB+j]) << (8*j));
            chk("we_onehot", 32'(log_we[rp+k]), 32'(1 << b));
            chk("waddr", 32'(log_addr[rp+k]), 32'(k));
            chk("wdata", 32'(log_data[rp+k]), 32'(d));
        end
        chk("ready_after_load", 32'(bank_ready), 32'(exp_ready));
        chk("idle_after_load", 32'(state_o), 32'd0);
        chk("not_busy", 32'(busy), 32'd0);
        chk("load_err_pulses", 32'(errn - e0), ok ? 32'd0 : 32'd1);
    endtask

    task automatic randomize_payload;
        for (int i = 0; i < DP*WB; i++) pl[i] = 8'($urandom);
    endtask

    initial begin
        int rp;
        int e0;
        int c0;
        int n;
        logic [7:0] b8;
        logic [3:0] code;

        idle(3);
        reset = 1'b0;
        idle(1);
        chk("rst_we", 32'(bram_we), 32'd0);
        chk("rst_wdata", 32'(bram_wdata), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_cmd", 32'({cmd_valid, cmd}), 32'd0);
        chk("rst_ready", 32'(bank_ready), 32'd0);
        chk("rst_misc", 32'({busy, err, state_o}), 32'd0);

        // Scenario 1: bank 1 with 11..88
        for (int i = 0; i < DP*WB; i++) pl[i] = 8'((i + 1) * 8'h11);
        rp = wn;
        run_load(1, -1, 0, 1'b1);
        chk("s1_first_word", 32'(log_data[rp]), 32'h2211);
        chk("s1_last_word", 32'(log_data[rp+3]), 32'h8877);

        // Scenario 2: command, dropped byte, done handshake
        c0 = cvn;
        send(8'h45);
        chk("cmd_valid_pulse", 32'(cmd_valid), 32'd1);
        chk("cmd_code", 32'(cmd), 32'd5);
        chk("state_comm", 32'(state_o), 32'd2);
        rp = wn;
        send(8'h00);
        idle(2);
        chk("comm_byte_dropped", 32'(wn - rp), 32'd0);
        chk("comm_holds", 32'(state_o), 32'd2);
        chk("cmd_single_pulse", 32'(cvn - c0), 32'd1);
        done = 1'b1;
        idle(1);
        done = 1'b0;
        chk("done_to_idle", 32'(state_o), 32'd0);
        chk("cmd_held", 32'(cmd), 32'd5);
        done = 1'b1;
        idle(2);
        done = 1'b0;
        chk("done_in_idle_noop", 32'(state_o), 32'd0);

        // Scenario 3: bad bank and invalid opcodes
        send(8'h02);
        chk("bad_bank_err", 32'(err), 32'd1);
        chk("bad_bank_idle", 32'(state_o), 32'd0);
        send(8'hC0);
        chk("bad_op_err", 32'(err), 32'd1);
        idle(1);
        chk("err_one_cycle", 32'(err), 32'd0);
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) b8 = {1'b1, 7'($urandom)};
            else b8 = {2'b00, 6'($urandom_range(NB, 63))};
            send(b8);
            chk("rand_invalid_err", 32'(err), 32'd1);
            chk("rand_invalid_idle", 32'(state_o), 32'd0);
        end

        // Scenario 4: timeout after a partial load of bank 0
        rp = wn;
        e0 = errn;
        send(8'h00);
        send(8'hA1);
        send(8'hB2);
        send(8'hC3);
        n = 0;
        while (n < TO + 5 && errn == e0) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency_ok", 32'(n >= TO && n <= TO + 1), 32'd1);
        idle(2);
        chk("timeout_one_err", 32'(errn - e0), 32'd1);
        chk("timeout_one_write", 32'(wn - rp), 32'd1);
        chk("timeout_w_addr", 32'(log_addr[rp]), 32'd0);
        chk("timeout_w_data", 32'(log_data[rp]), 32'hB2A1);
        chk("timeout_ready0", 32'(bank_ready[0]), 32'd0);
        chk("timeout_idle", 32'(state_o), 32'd0);

        // Scenario 5: load bank 0 with a byte arriving exactly at expiry, done held high
        randomize_payload();
        done = 1'b1;
        run_load(0, 2, TO - 1, 1'b1);
        done = 1'b0;
        chk("both_ready", 32'(bank_ready), 32'd3);
        randomize_payload();
        run_load(0, -1, 0, 1'b1);
        chk("reload_isolation", 32'(bank_ready), 32'd3);

        // Reset in the middle of a bank 1 load
        send(8'h01);
        chk("reload_clears_bit", 32'(bank_ready), 32'd1);
        send(8'h10);
        send(8'h20);
        send(8'h30);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        rp = wn;
        chk("rst_mid_ready", 32'(bank_ready), 32'd0);
        chk("rst_mid_idle", 32'(state_o), 32'd0);
        idle(5);
        chk("rst_mid_no_writes", 32'(wn - rp), 32'd0);
        exp_ready = '0;

        // Randomized loads and commands
        for (int r = 0; r < 4; r++) begin
            randomize_payload();
            run_load(int'($urandom_range(0, NB - 1)), -1, 0, 1'b1);
            code = 4'($urandom);
            send({2'b01, 2'($urandom), code});
            chk("rand_cmd", 32'(cmd), 32'(code));
            chk("rand_cmd_comm", 32'(state_o), 32'd2);
            done = 1'b1;
            idle(1);
            done = 1'b0;
            chk("rand_cmd_back", 32'(state_o), 32'd0);
        end

`ifdef LOADER_CHECKSUM_EN
        // Scenario 6: correct then wrong checksum on bank 1
        for (int i = 0; i < DP*WB; i++) pl[i] = 8'((i + 1) * 8'h11);
        run_load(1, -1, 0, 1'b1);
        chk("chk_good_ready", 32'(bank_ready[1]), 32'd1);
        run_load(1, -1, 0, 1'b0);
        chk("chk_bad_ready", 32'(bank_ready[1]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (total=%0d)", total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multi_bank_loader.md
Name: multi_bank_loader

Overview:
- Parametrised successor to the two-vector serial input front end.
- Consumes a received byte stream (valid/byte from the UART receiver) and decodes instruction bytes.
- Packs payload bytes into WORD_BYTES-wide words and writes them into one of NBANKS BRAM banks.
- Forwards 4-bit commands to the compute/transmit side and holds in a COMM state until that side signals done.

Parameters:
- NBANKS, 2, number of BRAM banks (1..64).
- DEPTH, 1024, words per bank load.
- WORD_BYTES, 1, bytes per BRAM word, assembled little-endian (1..4).
- ADDR_W, $clog2(DEPTH), BRAM address width.
- TIMEOUT_CYCLES, 100000, maximum idle clocks between payload bytes before a load aborts.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe; rx_byte valid
- rx_byte  in  8  received byte
- done  in  1  downstream finished the current command
- bram_we  out  NBANKS  one-hot write enable, one-cycle pulse per word
- bram_wdata  out  8*WORD_BYTES  assembled word
- bram_addr  out  ADDR_W  write address
- cmd_valid  out  1  one-cycle command strobe
- cmd  out  4  command code, held until the next command
- bank_ready  out  NBANKS  bank holds a complete, valid load
- busy  out  1  state != IDLE
- err  out  1  one-cycle error pulse
- state_o  out  2  current state, for debug LEDs

Behaviour:
- Reset values: all outputs 0; state IDLE; word and byte counters 0; timeout counter 0.
- Instruction byte, accepted only in IDLE:
  - [7:6]=00: LOAD bank [5:0].
  - [7:6]=01: COMMAND, code [3:0].
  - 10/11: invalid.
- IDLE, LOAD with bank < NBANKS:
  - go to LOAD; clear bank_ready[bank] next cycle; word_addr=0; byte_cnt=0.
- IDLE, LOAD with bank >= NBANKS, or invalid opcode:
  - err pulse; stay IDLE.
- IDLE, COMMAND:
  - cmd <= code; cmd_valid pulses the cycle after rx_valid; go to COMM.
- LOAD, each rx_valid:
  - byte goes into lane byte_cnt.
  - On the last lane (byte_cnt == WORD_BYTES-1): one cycle after rx_valid, bram_we[bank]=1 with bram_addr=word_addr and full word on bram_wdata; byte_cnt resets; word_addr increments.
  - Write at word_addr == DEPTH-1: set bank_ready[bank], return to IDLE in the same cycle as the write pulse.
  - Unwritten lanes never appear on the bus; lanes are cleared at each word start.
- LOAD timeout:
  - Counter resets on every rx_valid.
  - On reaching TIMEOUT_CYCLES: err pulse, IDLE, bank_ready[bank] stays 0, partial word discarded.
- COMM:
  - rx_valid ignored (byte dropped).
  - done == 1 returns to IDLE next cycle.
  - done asserted in IDLE or LOAD has no effect.
- bank_ready: bits for other banks are unaffected by any load.
- Simultaneous events: rx_valid and timeout expiry in the same cycle means the byte wins and the counter resets.
- reset mid-LOAD: aborts immediately, no further write pulses, all bank_ready cleared.
- Width rules: word_addr is ADDR_W bits and never wraps, because the load terminates at DEPTH-1. Timeout counter width is $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last word, LOAD expects one extra byte: the XOR of all DEPTH*WORD_BYTES payload bytes.
  - Match: bank_ready set, IDLE.
  - Mismatch: err pulse, bank_ready stays 0, IDLE.
  - Data already written to BRAM is not rolled back.
  - The timeout also covers the checksum byte.
- Undefined:
  - No checksum byte; bank_ready is set on the final write, as above.

Decomposition:
- Package loader_pkg:
  - state enum (IDLE, LOAD, COMM);
  - opcode constants OP_LOAD=2'b00, OP_CMD=2'b01;
  - field position constants for opcode [7:6], bank [5:0], code [3:0].
- Sub-module word_packer, parameter WORD_BYTES:
  - byte lane counter, lane register, word_done strobe;
  - clear input, used at load start and on abort.

Test Plan:
All scenarios use NBANKS=2, DEPTH=4, WORD_BYTES=2.
1. Load bank 1: bytes 0x01, then 11 22 33 44 55 66 77 88 -> bram_we=2'b10 pulses at addr 0..3 with data 2211, 4433, 6655, 8877; bank_ready=2'b10; state IDLE.
2. Command byte 0x45 -> cmd=5, one cmd_valid pulse, state COMM; send byte 0x00 -> dropped, no write; done=1 -> IDLE next cycle.
3. Invalid input: byte 0x02 (bank 2) -> err pulse, no state change; byte 0xC0 -> err pulse.
4. Timeout: load bank 0, send 3 payload bytes, then silence for TIMEOUT_CYCLES -> exactly 1 write (addr 0), err pulse, IDLE, bank_ready[0]=0.
5. Reload isolation: bank_ready=2'b11, start load of bank 0 -> bank_ready=2'b10 during LOAD, returns to 2'b11 on completion; reset asserted mid-load -> bank_ready=0, no further bram_we.
6. LOADER_CHECKSUM_EN: payload as in scenario 1 with trailing byte 0x88 -> bank_ready[1]=1; wrong checksum byte 0x00 -> err pulse, bank_ready[1]=0.
